sm_div_seq: RTL and testbench



---
 rtl/sm_div_seq.sv | 152 +++++++++++++++
 tb/tb_sm_div_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : sm_div_seq
// Description : Multi-cycle sign-magnitude restoring divider. Accepts an
//               operand pair on start_i and performs one restoring step per
//               clock, MSB of the dividend magnitude first. It returns a
//               sign-magnitude quotient and remainder with a one-cycle done
//               pulse and a divide-by-zero flag.
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               start_i    - request, sampled in IDLE or DONE
//               a_i, b_i   - dividend / divisor, sign-magnitude
//               busy_o     - division in progress
//               done_o     - one-cycle pulse, results valid
//               q_o, r_o   - quotient / remainder, sign-magnitude
//               div_zero_o - divisor magnitude was zero
// Options     : SM_DIV_EARLY_EXIT_EN - when defined, an operation with a zero
//               divisor magnitude or |a| < |b| finishes after one CALC cycle.
//               Results are identical either way.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             div_zero_o
);

  localparam int            M      = WIDTH - 1;
  localparam int            CW     = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  // dvd_q starts as the dividend magnitude; each step shifts one dividend bit
  // out of the top and one quotient bit into the bottom, so after M steps it
  // holds the quotient magnitude.
  logic [M-1:0]    dvd_q;
  logic [M-1:0]    bmag_q;
  logic [M-1:0]    rem_q;
  logic [CW-1:0]   cnt_q;
  logic            sa_q;
  logic            sb_q;
`ifdef SM_DIV_EARLY_EXIT_EN
  logic            early_q;
`endif

  logic [M:0]      rem_sh_d;
  logic [M:0]      rem_d;
  logic            ge_d;
  logic [M-1:0]    dvd_d;
  logic [M-1:0]    qmag_d;
  logic [M:0]      rmag_d;
  logic            last_d;
  logic            bzero_d;

  always_comb begin
    rem_sh_d = {rem_q, dvd_q[M-1]};
    ge_d     = (rem_sh_d >= {1'b0, bmag_q});
    rem_d    = ge_d ? (rem_sh_d - {1'b0, bmag_q}) : rem_sh_d;
    dvd_d    = {dvd_q[M-2:0], ge_d};
    bzero_d  = (bmag_q == '0);
    qmag_d   = dvd_d;
    rmag_d   = rem_d;
    last_d   = (cnt_q == C_LAST);
`ifdef SM_DIV_EARLY_EXIT_EN
    // Shortcut results match what the full restoring run would produce:
    // zero divisor gives all-ones quotient, |a| < |b| gives zero quotient,
    // and in both cases the remainder is the dividend magnitude.
    if (early_q) begin
      qmag_d = {M{bzero_d}};
      rmag_d = {1'b0, dvd_q};
      last_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      bmag_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
`ifdef SM_DIV_EARLY_EXIT_EN
      early_q    <= 1'b0;
`endif
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      q_o        <= '0;
      r_o        <= '0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_CALC: begin
          // start_i is deliberately ignored here.
          // The remainder after a step is always < 2^M, so the top bit of
          // rem_d can be dropped when storing it.
          rem_q <= rem_d[M-1:0];
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            state_q    <= S_DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            // Zero magnitudes are forced positive: no negative zero output.
            q_o        <= {(sa_q ^ sb_q) & (|qmag_d), qmag_d};
            r_o        <= {sa_q & (|rmag_d), rmag_d[M-1:0]};
            div_zero_o <= bzero_d;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back
          // operation with no idle gap.
          if (start_i) begin
            state_q <= S_CALC;
            busy_o  <= 1'b1;
            dvd_q   <= a_i[M-1:0];
            bmag_q  <= b_i[M-1:0];
            rem_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= a_i[M];
            sb_q    <= b_i[M];
`ifdef SM_DIV_EARLY_EXIT_EN
            early_q <= (b_i[M-1:0] == '0) || (a_i[M-1:0] < b_i[M-1:0]);
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_div_seq
// Description : Self-checking bench for sm_div_seq. Expected results are
//               queued when an operation is started and compared, together
//               with the completion cycle, when done_o pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_div_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] q_o;
  logic [7:0] r_o;
  logic       div_zero_o;

  sm_div_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .q_o        (q_o),
    .r_o        (r_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef SM_DIV_EARLY_EXIT_EN
    if ((b[6:0] == 7'd0) || (a[6:0] < b[6:0])) return 1;
`endif
    return 7;
  endfunction

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t       v;
    logic [6:0] qm;
    logic [6:0] rm;
    v.a = a;
    v.b = b;
    if (b[6:0] == 7'd0) begin
      qm = 7'h7F;
      rm = a[6:0];
    end else begin
      qm = a[6:0] / b[6:0];
      rm = a[6:0] % b[6:0];
    end
    v.q  = {(a[7] ^ b[7]) & (qm != 7'd0), qm};
    v.r  = {a[7] & (rm != 7'd0), rm};
    v.dz = (b[6:0] == 7'd0);
    return v;
  endfunction

  task automatic push_exp(input vec_t v, input int at);
    exp_t e;
    e.q  = v.q;
    e.r  = v.r;
    e.dz = v.dz;
    e.at = at;
    sb_q.push_back(e);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("q", {24'd0, q_o}, {24'd0, mon_e.q});
        chk("r", {24'd0, r_o}, {24'd0, mon_e.r});
        chk("div_zero", {31'd0, div_zero_o}, {31'd0, mon_e.dz});
        chk("done_cycle", cyc, mon_e.at);
        chk("busy_in_done", {31'd0, busy_o}, 32'd0);
      end
    end
  end

  task automatic wait_done(input string nm);
    for (int k = 0; k < 40; k++) begin
      if (done_o === 1'b1) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout actual=no_done required=done (t=%0t)", nm, $time);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    int busy_n;
    bit seen;
    lat = exp_lat(v.a, v.b);
    @(negedge clk);
    a_i     = v.a;
    b_i     = v.b;
    start_i = 1'b1;
    push_exp(v, cyc + 1 + lat);
    @(negedge clk);
    start_i = 1'b0;
    busy_n  = 0;
    seen    = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy_o === 1'b1) busy_n++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL op_timeout actual=no_done required=done a=%h b=%h", v.a, v.b);
    end else begin
      chk("busy_cycles", busy_n, lat);
    end
  endtask

  vec_t tbl[13];
  vec_t v1;
  vec_t v2;

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = 8'h00;
    b_i     = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_q", {24'd0, q_o}, 32'd0);
    chk("rst_r", {24'd0, r_o}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero_o}, 32'd0);
    rst_n = 1'b1;

    //            a      b      q      r      dz
    tbl[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};
    tbl[1]  = '{8'hE4, 8'h07, 8'h8E, 8'h82, 1'b0};
    tbl[2]  = '{8'h64, 8'h87, 8'h8E, 8'h02, 1'b0};
    tbl[3]  = '{8'h05, 8'h80, 8'hFF, 8'h05, 1'b1};
    tbl[4]  = '{8'h83, 8'h05, 8'h00, 8'h83, 1'b0};
    tbl[5]  = '{8'hE4, 8'h87, 8'h0E, 8'h82, 1'b0};
    tbl[6]  = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{8'h80, 8'h85, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0};
    tbl[9]  = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0};
    tbl[10] = '{8'hFF, 8'h82, 8'h3F, 8'h81, 1'b0};
    tbl[11] = '{8'h00, 8'h00, 8'h7F, 8'h00, 1'b1};
    tbl[12] = '{8'h80, 8'h00, 8'hFF, 8'h00, 1'b1};

    for (int i = 0; i < 13; i++) run_op(tbl[i]);

    for (int i = 0; i < 16; i++) begin
      v1 = model(8'($urandom), 8'($urandom));
      run_op(v1);
    end

    // A start pulse three cycles into a division must be ignored.
    v1 = tbl[0];
    @(negedge clk);
    a_i     = v1.a;
    b_i     = v1.b;
    start_i = 1'b1;
    push_exp(v1, cyc + 1 + exp_lat(v1.a, v1.b));
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    a_i     = 8'h11;
    b_i     = 8'h01;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("ignore_start");
    repeat (3) @(negedge clk);

    // Back-to-back: start held during the done cycle is accepted at once.
    v1 = tbl[0];
    v2 = tbl[1];
    @(negedge clk);
    a_i     = v1.a;
    b_i     = v1.b;
    start_i = 1'b1;
    push_exp(v1, cyc + 1 + exp_lat(v1.a, v1.b));
    @(negedge clk);
    start_i = 1'b0;
    wait_done("b2b_first");
    a_i     = v2.a;
    b_i     = v2.b;
    start_i = 1'b1;
    push_exp(v2, cyc + 1 + exp_lat(v2.a, v2.b));
    @(negedge clk);
    start_i = 1'b0;
    chk("b2b_busy", {31'd0, busy_o}, 32'd1);
    wait_done("b2b_second");

    // Reset mid-CALC aborts the operation with no done pulse.
    @(negedge clk);
    a_i     = 8'h64;
    b_i     = 8'h07;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_q", {24'd0, q_o}, 32'd0);
    chk("abort_r", {24'd0, r_o}, 32'd0);
    chk("abort_div_zero", {31'd0, div_zero_o}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_op(tbl[0]);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
